// File: rtl/carrier_demod_pkg.sv
// Shared types for the carrier demodulator.
// FSM state encoding and FIFO entry layout.
package carrier_demod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } sym_state_t;

    // Entry layout is {level, duration}; level sits in the MSB.
    localparam int  LEVEL_W    = 1;
    localparam logic LVL_MARK  = 1'b1;
    localparam logic LVL_SPACE = 1'b0;

    function automatic int entry_width(input int dur_w);
        return dur_w + LEVEL_W;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head.
// Push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty && !clr;
    assign do_push = push && !clr && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; clr empties the queue without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; reset clears entries so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/carrier_demod.sv
// Carrier envelope detector and mark/space duration meter.
// Symbols are queued for the peripheral register interface.
module carrier_demod
    import carrier_demod_pkg::*;
#(
    parameter int TIMER_WIDTH = 11,
    parameter int DUR_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    input  logic                   en,
    input  logic                   rx_in,
    input  logic                   invert,
    input  logic [TIMER_WIDTH-1:0] timeout,
    output logic                   carrier_present,
    output logic                   sym_valid,
    input  logic                   sym_ready,
    output logic                   sym_level,
    output logic [DUR_WIDTH-1:0]   sym_duration,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam int EW = entry_width(DUR_WIDTH);
    localparam logic [DUR_WIDTH-1:0] DUR_MAX = '1;

    logic                   sync1;
    logic                   sync2;
    logic                   prev;
    logic                   lvl;
    logic                   rx_edge;
    logic [TIMER_WIDTH-1:0] gap_cnt;
    sym_state_t             state;
    logic [DUR_WIDTH-1:0]   dur_cnt;
    logic [DUR_WIDTH-1:0]   dur_inc;
    logic                   push;
    logic [EW-1:0]          push_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [EW-1:0]          fifo_head;
    logic                   drop;

    assign lvl     = sync2 ^ invert;
    assign rx_edge = (lvl != prev);
    assign dur_inc = (dur_cnt == DUR_MAX) ? dur_cnt
                                          : dur_cnt + DUR_WIDTH'(1);

    // Input synchronizer and edge history; runs even when disabled.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
            prev  <= lvl;
        end
    end

    // Envelope: any edge re-arms the gap timer; expiry drops carrier.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gap_cnt         <= '0;
            carrier_present <= 1'b0;
        end else if (!en) begin
            gap_cnt         <= '0;
            carrier_present <= 1'b0;
        end else if (rx_edge) begin
            gap_cnt         <= timeout;
            carrier_present <= 1'b1;
        end else if (gap_cnt == '0) begin
            carrier_present <= 1'b0;
        end else begin
            gap_cnt <= gap_cnt - TIMER_WIDTH'(1);
        end
    end

    // Symbol emission on each envelope change or saturated space.
    always_comb begin
        push      = 1'b0;
        push_data = '0;
        unique case (state)
            ST_MARK: begin
                if (!carrier_present) begin
                    push      = en;
                    push_data = {LVL_MARK, dur_cnt};
                end
            end
            ST_SPACE: begin
                if (carrier_present || dur_cnt == DUR_MAX) begin
                    push      = en;
                    push_data = {LVL_SPACE, dur_cnt};
                end
            end
            default: ;
        endcase
    end

    // Mark/space state and duration counter.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= ST_IDLE;
            dur_cnt <= '0;
        end else if (!en) begin
            state   <= ST_IDLE;
            dur_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (carrier_present) begin
                        state   <= ST_MARK;
                        dur_cnt <= DUR_WIDTH'(1);
                    end
                end
                ST_MARK: begin
                    if (!carrier_present) begin
                        state   <= ST_SPACE;
                        dur_cnt <= DUR_WIDTH'(1);
                    end else begin
                        dur_cnt <= dur_inc;
                    end
                end
                ST_SPACE: begin
                    if (carrier_present) begin
                        state   <= ST_MARK;
                        dur_cnt <= DUR_WIDTH'(1);
                    end else if (dur_cnt == DUR_MAX) begin
                        state   <= ST_IDLE;
                        dur_cnt <= '0;
                    end else begin
                        dur_cnt <= dur_inc;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    dur_cnt <= '0;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (sys_rst_n),
        .clr       (!en),
        .push      (push),
        .push_data (push_data),
        .pop       (sym_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign drop         = push && fifo_full && !sym_ready;
    assign sym_valid    = !fifo_empty;
    assign sym_level    = fifo_head[EW-1];
    assign sym_duration = fifo_head[DUR_WIDTH-1:0];

    // Sticky drop flag; a clear beats a same-cycle drop.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overflow <= 1'b0;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_carrier_demod.sv
// Self-checking bench for carrier_demod.
// Expected symbols come from a burst-level model of the rx edge times.
module tb_carrier_demod;

    typedef logic [8:0] ent_t;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rx_in = 1'b0;
    logic        invert = 1'b0;
    logic [10:0] timeout = 11'd25;
    logic        carrier_present;
    logic        sym_valid;
    logic        sym_ready = 1'b0;
    logic        sym_level;
    logic [7:0]  sym_duration;
    logic        overflow;
    logic        clr_overflow = 1'b0;

    int checks = 0;
    int errors = 0;
    ent_t exp_q[$];
    ent_t got_q[$];

    carrier_demod #(
        .TIMER_WIDTH (11),
        .DUR_WIDTH   (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk             (clk),
        .sys_rst_n       (sys_rst_n),
        .en              (en),
        .rx_in           (rx_in),
        .invert          (invert),
        .timeout         (timeout),
        .carrier_present (carrier_present),
        .sym_valid       (sym_valid),
        .sym_ready       (sym_ready),
        .sym_level       (sym_level),
        .sym_duration    (sym_duration),
        .overflow        (overflow),
        .clr_overflow    (clr_overflow)
    );

    always #5 clk = ~clk;

    // Record every symbol the consumer pops.
    always @(negedge clk)
        if (sys_rst_n && sym_valid && sym_ready)
            got_q.push_back({sym_level, sym_duration});

    initial begin
        #3000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Toggle rx_in after each gap (in cycles), then idle for tail cycles.
    task automatic play(input int gaps[$], input int tail);
        foreach (gaps[i]) begin
            repeat (gaps[i]) @(posedge clk);
            #1 rx_in = ~rx_in;
        end
        repeat (tail) @(posedge clk);
        #1;
    endtask

    function automatic ent_t sat(input logic lv, input int d);
        ent_t e;
        e = {lv, (d > 255) ? 8'hFF : 8'(d)};
        return e;
    endfunction

    // Group toggles into bursts (gap <= T+1 keeps carrier up).
    task automatic model(input int gaps[$], input int t);
        int tm[$];
        int acc;
        int first;
        int last;
        acc = 0;
        foreach (gaps[i]) begin
            acc += gaps[i];
            tm.push_back(acc);
        end
        first = tm[0];
        last  = tm[0];
        for (int i = 1; i < tm.size(); i++) begin
            if (tm[i] - last <= t + 1) begin
                last = tm[i];
            end else begin
                exp_q.push_back(sat(1'b1, last - first + t + 1));
                exp_q.push_back(sat(1'b0, tm[i] - last - t - 1));
                first = tm[i];
                last  = tm[i];
            end
        end
        exp_q.push_back(sat(1'b1, last - first + t + 1));
        exp_q.push_back(sat(1'b0, 255));
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (carrier_present !== 1'b0) begin
            errors++;
            $display("FAIL reset_carrier got %b want 0", carrier_present);
        end
        checks++;
        if (sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", sym_valid);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow got %b want 0", overflow);
        end
        checks++;
        if ({sym_level, sym_duration} !== 9'h000) begin
            errors++;
            $display("FAIL reset_head got %h want 000",
                     {sym_level, sym_duration});
        end
        sys_rst_n = 1'b1;
        @(posedge clk);
        #1 en = 1'b1;
        sym_ready = 1'b1;
    endtask

    task automatic test_burst_gap();
        int g[$];
        timeout = 11'd25;
        got_q.delete();
        exp_q.delete();
        g.push_back(5);
        repeat (19) g.push_back(10);
        exp_q.push_back({1'b1, 8'd216});
        exp_q.push_back({1'b0, 8'd255});
        play(g, 340);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL burst_gap_count got %0d want %0d",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL burst_gap_sym%0d got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (carrier_present !== 1'b0 || sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_gap_idle got %b%b want 00",
                     carrier_present, sym_valid);
        end
    endtask

    task automatic test_two_bursts();
        int g[$];
        got_q.delete();
        exp_q.delete();
        g.push_back(5);
        repeat (19) g.push_back(10);
        g.push_back(100);
        repeat (19) g.push_back(10);
        exp_q.push_back({1'b1, 8'd216});
        exp_q.push_back({1'b0, 8'd74});
        exp_q.push_back({1'b1, 8'd216});
        exp_q.push_back({1'b0, 8'd255});
        play(g, 340);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL two_bursts_count got %0d want %0d",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL two_bursts_sym%0d got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_invert();
        int bad;
        bad = 0;
        #1 en = 1'b0;
        invert = 1'b1;
        rx_in  = 1'b1;
        repeat (6) @(posedge clk);
        #1 en = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (carrier_present !== 1'b0 || sym_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL invert_quiet got %0d active cycles want 0", bad);
        end
        @(posedge clk);
        #1 en = 1'b0;
        invert = 1'b0;
        rx_in  = 1'b0;
        repeat (6) @(posedge clk);
        #1 en = 1'b1;
    endtask

    task automatic test_overflow();
        int g1[$];
        int g2[$];
        int n;
        timeout = 11'd10;
        sym_ready = 1'b0;
        got_q.delete();
        exp_q.delete();
        g1 = {3, 5, 5, 5, 40, 5, 5, 5, 40, 5, 5, 5};
        model(g1, 10);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        play(g1, 320);
        checks++;
        if (overflow !== 1'b1 || sym_valid !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set got ovf=%b valid=%b want 1 1",
                     overflow, sym_valid);
        end
        clr_overflow = 1'b1;
        @(posedge clk);
        #1 clr_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got %b want 0", overflow);
        end
        void'(exp_q.pop_front());
        g2 = {3, 5, 5, 5};
        model(g2, 10);
        n = 0;
        fork
            play(g2, 320);
            begin
                while (!carrier_present && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                while (carrier_present && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                #1 sym_ready = 1'b1;
            end
        join
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL overflow_wait got timeout want carrier pulse");
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_popfull got %b want 0", overflow);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL overflow_count got %0d want %0d",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL overflow_sym%0d got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_en_drop();
        timeout = 11'd10;
        sym_ready = 1'b0;
        got_q.delete();
        play('{3, 5, 5, 5, 40, 5, 5}, 2);
        checks++;
        if (sym_valid !== 1'b1 || {sym_level, sym_duration} !== {1'b1, 8'd26}) begin
            errors++;
            $display("FAIL en_drop_queued got v=%b head=%h want 1 11a",
                     sym_valid, {sym_level, sym_duration});
        end
        en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (sym_valid !== 1'b0 || carrier_present !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_flush got v=%b c=%b want 0 0",
                     sym_valid, carrier_present);
        end
        repeat (4) @(posedge clk);
        #1 en = 1'b1;
        sym_ready = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() !== 0 || sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_nosym got %0d symbols want 0",
                     got_q.size());
        end
    endtask

    task automatic test_async_reset();
        timeout = 11'd10;
        sym_ready = 1'b0;
        play('{3, 5, 5, 5, 40, 5, 5}, 2);
        @(negedge clk);
        #2 sys_rst_n = 1'b0;
        rx_in = 1'b0;
        #1;
        checks++;
        if (carrier_present !== 1'b0 || sym_valid !== 1'b0 ||
            overflow !== 1'b0 || {sym_level, sym_duration} !== 9'h000) begin
            errors++;
            $display("FAIL async_reset got c=%b v=%b o=%b head=%h want 0 0 0 000",
                     carrier_present, sym_valid, overflow,
                     {sym_level, sym_duration});
        end
        repeat (2) @(negedge clk);
        sys_rst_n = 1'b1;
        sym_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int g[$];
        int t;
        int nb;
        int nt;
        sym_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            t = $urandom_range(3, 40);
            timeout = 11'(t);
            g.delete();
            got_q.delete();
            exp_q.delete();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                nt = $urandom_range(1, 12);
                g.push_back(b == 0 ? 3 : $urandom_range(t + 2, 320));
                for (int k = 1; k < nt; k++)
                    g.push_back($urandom_range(1, t + 1));
            end
            model(g, t);
            play(g, t + 300);
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL random%0d_count got %0d want %0d",
                         f, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random%0d_sym%0d got %h want %h",
                             f, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_burst_gap();
        test_two_bursts();
        test_invert();
        test_overflow();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
